mem_store_checker: RTL

- Synthesizable self-check block for the pipelined MIPS core. Monitors the data-memory write bus (memwrite, dataadr, writedata) against a programmed, ordered table of expected stores.
- Raises pass/fail plus diagnostic outputs, so an FPGA build or any bench gets a hardware verdict without a procedural checker.
- Generalises the single "final store" check to N ordered stores, a scratch address that is ignored, and a cycle timeout.

---
 rtl/mem_store_checker.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_store_checker.sv
// mem_store_checker: watches the core's data-memory write bus and compares
// every non-scratch store, in order, against a programmed table of expected
// (address, data) pairs. It produces a sticky pass/fail verdict, a fail
// reason and some diagnostics.
// Optional feature: define MEM_STORE_CHECKER_HISTORY_EN to add a 4-deep
// history of the most recent non-ignored stores (hist_sel/hist_addr/hist_data).
module mem_store_checker #(
    parameter int unsigned   N_EXP       = 4,
    parameter int unsigned   AW          = 32,
    parameter int unsigned   DW          = 32,
    parameter logic [AW-1:0] IGNORE_ADDR = AW'(80),
    parameter int unsigned   TIMEOUT     = 4096
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        prog_we,
    input  logic [$clog2((N_EXP > 1) ? N_EXP : 2)-1:0]  prog_idx,
    input  logic [AW-1:0]                               prog_addr,
    input  logic [DW-1:0]                               prog_data,
    input  logic [$clog2(N_EXP+1)-1:0]                  n_used,
    input  logic                                        start,
    input  logic                                        memwrite,
    input  logic [AW-1:0]                               dataadr,
    input  logic [DW-1:0]                               writedata,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        pass,
    output logic [1:0]                                  fail_code,
    output logic [$clog2(N_EXP+1)-1:0]                  match_cnt,
    output logic [AW-1:0]                               fail_addr,
    output logic [DW-1:0]                               fail_data,
    output logic [$clog2(TIMEOUT+1):0]                  cycle_cnt
`ifdef MEM_STORE_CHECKER_HISTORY_EN
    ,
    input  logic [1:0]                                  hist_sel,
    output logic [AW-1:0]                               hist_addr,
    output logic [DW-1:0]                               hist_data
`endif
);

    localparam int unsigned IW = $clog2((N_EXP > 1) ? N_EXP : 2);
    localparam int unsigned CW = $clog2(N_EXP + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1) + 1;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_BAD_N    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_PASS  = 2'd2,
        S_FAIL  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] match_cnt_q, match_cnt_d;
    logic [CW-1:0] n_used_q, n_used_d;
    logic [TW-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [1:0]    fail_code_q, fail_code_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [DW-1:0] fail_data_q, fail_data_d;
    logic          busy_q, done_q, pass_q;

    logic [AW-1:0] tbl_addr_q [N_EXP];
    logic [DW-1:0] tbl_data_q [N_EXP];

    logic [IW-1:0] cur_idx;
    logic [TW-1:0] cycle_inc;
    logic          is_ignored, cur_hit, is_last, tmo_hit, start_ok, tbl_we;

    // Per-cycle decode of the store bus against the next expected entry;
    // case equality makes an X on the bus count as a mismatch.
    always_comb begin
        cur_idx    = IW'(match_cnt_q);
        is_ignored = (dataadr === IGNORE_ADDR);
        cur_hit    = (dataadr === tbl_addr_q[cur_idx]) && (writedata === tbl_data_q[cur_idx]);
        is_last    = (CW'(match_cnt_q + CW'(1)) == n_used_q);
        cycle_inc  = (&cycle_cnt_q) ? cycle_cnt_q : TW'(cycle_cnt_q + TW'(1));
        tmo_hit    = (TIMEOUT != 0) && (32'(cycle_inc) >= TIMEOUT);
        start_ok   = (n_used != '0) && (32'(n_used) <= N_EXP);
        tbl_we     = prog_we && (state_q != S_ARMED) && (32'(prog_idx) < N_EXP);
    end

    // Next-state and verdict logic; a final match beats a same-cycle timeout.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        n_used_d    = n_used_q;
        cycle_cnt_d = cycle_cnt_q;
        fail_code_d = fail_code_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        case (state_q)
            S_ARMED: begin
                cycle_cnt_d = cycle_inc;
                if (memwrite && !is_ignored && cur_hit) begin
                    match_cnt_d = CW'(match_cnt_q + CW'(1));
                    if (is_last) begin
                        state_d = S_PASS;
                    end
                end else if (memwrite && !is_ignored) begin
                    state_d     = S_FAIL;
                    fail_code_d = FC_MISMATCH;
                    fail_addr_d = dataadr;
                    fail_data_d = writedata;
                end
                if ((state_d == S_ARMED) && tmo_hit) begin
                    state_d     = S_FAIL;
                    fail_code_d = FC_TIMEOUT;
                end
            end
            default: begin
                if (start) begin
                    match_cnt_d = '0;
                    cycle_cnt_d = '0;
                    fail_code_d = FC_NONE;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    if (start_ok) begin
                        n_used_d = n_used;
                        state_d  = S_ARMED;
                    end else begin
                        state_d     = S_FAIL;
                        fail_code_d = FC_BAD_N;
                    end
                end
            end
        endcase
    end

    // State, counters and registered verdict outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            match_cnt_q <= '0;
            n_used_q    <= '0;
            cycle_cnt_q <= '0;
            fail_code_q <= FC_NONE;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            n_used_q    <= n_used_d;
            cycle_cnt_q <= cycle_cnt_d;
            fail_code_q <= fail_code_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            busy_q      <= (state_d == S_ARMED);
            done_q      <= (state_d == S_PASS) || (state_d == S_FAIL);
            pass_q      <= (state_d == S_PASS);
        end
    end

    // Expected-store table; writable whenever no check is running so it can
    // be reprogrammed between runs, and it survives re-arming.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(N_EXP); i++) begin
                tbl_addr_q[i] <= '0;
                tbl_data_q[i] <= '0;
            end
        end else if (tbl_we) begin
            tbl_addr_q[prog_idx] <= prog_addr;
            tbl_data_q[prog_idx] <= prog_data;
        end
    end

`ifdef MEM_STORE_CHECKER_HISTORY_EN
    logic [AW-1:0] hist_addr_q [4];
    logic [DW-1:0] hist_data_q [4];

    // Shift in every non-ignored store seen while armed; slot 0 is newest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                hist_addr_q[i] <= '0;
                hist_data_q[i] <= '0;
            end
        end else if ((state_q != S_ARMED) && start) begin
            for (int i = 0; i < 4; i++) begin
                hist_addr_q[i] <= '0;
                hist_data_q[i] <= '0;
            end
        end else if ((state_q == S_ARMED) && memwrite && !is_ignored) begin
            for (int i = 3; i > 0; i--) begin
                hist_addr_q[i] <= hist_addr_q[i-1];
                hist_data_q[i] <= hist_data_q[i-1];
            end
            hist_addr_q[0] <= dataadr;
            hist_data_q[0] <= writedata;
        end
    end

    assign hist_addr = hist_addr_q[hist_sel];
    assign hist_data = hist_data_q[hist_sel];
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_code = fail_code_q;
    assign match_cnt = match_cnt_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule
